mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port: data has priority unless
// fetch has been starved, one transaction in flight, read responses guarded by a timeout.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner,
  output logic        err
);

  localparam int unsigned WaitW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]  StarveMax = 3'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_we;
  logic               r_owner;
  logic [2:0]         r_starve_cnt;
  logic [WaitW-1:0]   r_wait_cnt;
  logic               r_err;
  logic               r_if_rvalid;
  logic               r_d_rvalid;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_d_rdata;

  logic               w_idle;
  logic               w_starved;
  logic               w_if_win;
  logic               w_d_win;
  logic               w_grant;
  logic               w_rsp_valid;
  logic [31:0]        w_rsp_data;
  logic               w_timeout;

  assign w_idle    = (r_state == StIdle);
  assign w_starved = (r_starve_cnt == StarveMax);
  assign w_if_win  = if_req & (~d_req | w_starved);
  assign w_d_win   = d_req & ~w_if_win;

  // Gated by reset so no grant is visible (or captured) while reset is held.
  assign if_gnt  = reset & w_idle & w_if_win;
  assign d_gnt   = reset & w_idle & w_d_win;
  assign w_grant = if_gnt | d_gnt;

  always_comb begin
    w_state_d   = r_state;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 32'h0;
    w_timeout   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant) w_state_d = StIssue;
      end
      StIssue: begin
        if (mem_ready) w_state_d = r_we ? StIdle : StWait;
      end
      StWait: begin
        // A response arriving on the expiry cycle takes precedence over the timeout.
        if (mem_rvalid) begin
          w_rsp_valid = 1'b1;
          w_rsp_data  = mem_rdata;
          w_state_d   = StIdle;
        end else if (r_wait_cnt == WaitW'(TIMEOUT - 1)) begin
          w_rsp_valid = 1'b1;
          w_timeout   = 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_we         <= 1'b0;
      r_owner      <= 1'b0;
      r_starve_cnt <= 3'd0;
      r_wait_cnt   <= '0;
      r_err        <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_if_rdata   <= 32'h0;
      r_d_rdata    <= 32'h0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_addr  <= d_gnt ? d_addr : if_addr;
        r_wdata <= d_gnt ? d_wdata : 32'h0;
        r_we    <= d_gnt & d_we;
        r_owner <= d_gnt;
        if (d_gnt && if_req) begin
          if (!w_starved) r_starve_cnt <= r_starve_cnt + 3'd1;
        end else begin
          r_starve_cnt <= 3'd0;
        end
      end
      if (r_state == StIssue) begin
        r_wait_cnt <= '0;
      end else if (r_state == StWait) begin
        r_wait_cnt <= r_wait_cnt + WaitW'(1);
      end
      r_if_rvalid <= w_rsp_valid & ~r_owner;
      r_d_rvalid  <= w_rsp_valid & r_owner;
      if (w_rsp_valid) begin
        if (r_owner) r_d_rdata <= w_rsp_data;
        else         r_if_rdata <= w_rsp_data;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign mem_req   = (r_state == StIssue);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = ~w_idle;
  assign owner     = r_owner;
  assign err       = r_err;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed latencies, sequences and data.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 15;
  localparam byte ChF = 8'h46;
  localparam byte ChD = 8'h44;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy, owner, err;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .err(err)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder configuration (written only by the main process).
  int          cfg_ready_delay = 0;
  int          cfg_rv_delay = 0;
  logic [31:0] cfg_rdata = 32'h0;
  bit          cfg_manual = 1'b0;
  logic        cfg_man_rvalid = 1'b0;
  logic [31:0] cfg_man_rdata = 32'h0;

  initial begin
    int rq_n;
    int wt_n;
    rq_n = 0;
    wt_n = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (cfg_manual) begin
        mem_rvalid = cfg_man_rvalid;
        mem_rdata  = cfg_man_rdata;
      end else begin
        if (mem_req) begin
          if (rq_n >= cfg_ready_delay) mem_ready = 1'b1;
          rq_n++;
        end else begin
          rq_n = 0;
        end
        if (busy && !mem_req) begin
          if (cfg_rv_delay >= 0 && wt_n == cfg_rv_delay) begin
            mem_rvalid = 1'b1;
            mem_rdata  = cfg_rdata;
          end
          wt_n++;
        end else begin
          wt_n = 0;
        end
      end
    end
  end

  // Reference model: one in-flight transaction record plus delivered responses.
  bit          m_busy = 0, m_acc = 0, m_err = 0, m_owner = 0, m_rv_if = 0, m_rv_d = 0;
  bit          m_tx_we = 0;
  logic [31:0] m_tx_addr = 0, m_tx_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
  int          m_waited = 0, m_starve = 0;

  function automatic bit fetch_wins();
    return if_req && (!d_req || m_starve == STARVE_MAX);
  endfunction

  function automatic bit data_wins();
    return d_req && !fetch_wins();
  endfunction

  task automatic deliver(input logic [31:0] data);
    if (m_owner) begin m_rv_d = 1; m_d_rdata = data; end
    else begin m_rv_if = 1; m_if_rdata = data; end
    m_busy = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 0; m_acc = 0; m_err = 0; m_owner = 0; m_rv_if = 0; m_rv_d = 0;
      m_tx_we = 0; m_tx_addr = 0; m_tx_wdata = 0; m_if_rdata = 0; m_d_rdata = 0;
      m_waited = 0; m_starve = 0;
    end else begin
      m_rv_if = 0;
      m_rv_d  = 0;
      if (!m_busy) begin
        if (data_wins()) begin
          m_tx_addr = d_addr; m_tx_wdata = d_wdata; m_tx_we = d_we; m_owner = 1;
          m_busy = 1; m_acc = 0;
          m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
        end else if (fetch_wins()) begin
          m_tx_addr = if_addr; m_tx_wdata = 0; m_tx_we = 0; m_owner = 0;
          m_busy = 1; m_acc = 0; m_starve = 0;
        end
      end else if (!m_acc) begin
        if (mem_ready) begin
          if (m_tx_we) m_busy = 0;
          else begin m_acc = 1; m_waited = 0; end
        end
      end else begin
        m_waited++;
        if (mem_rvalid) deliver(mem_rdata);
        else if (m_waited == TIMEOUT) begin deliver(32'h0); m_err = 1; end
      end
    end
  end

  // Per-cycle compare and event recording (sole writer of the recorder variables).
  int          cyc = 0, last_if_gnt = 0, last_d_gnt = 0, last_if_rv = 0, last_d_rv = 0;
  int          if_rv_cnt = 0, d_rv_cnt = 0, mreq_cnt = 0;
  logic [31:0] last_req_addr = 0, last_req_wdata = 0;
  byte         gseq[$];

  initial forever begin
    bit e_mem_req;
    @(negedge clk);
    e_mem_req = m_busy && !m_acc;
    chk("if_gnt", if_gnt, reset && !m_busy && fetch_wins());
    chk("d_gnt", d_gnt, reset && !m_busy && data_wins());
    chk("mem_req", mem_req, e_mem_req);
    if (e_mem_req || !reset) begin
      chk("mem_we", mem_we, m_tx_we);
      chk("mem_addr", mem_addr, m_tx_addr);
      chk("mem_wdata", mem_wdata, m_tx_wdata);
    end
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
    chk("err", err, m_err);
    chk("if_rvalid", if_rvalid, m_rv_if);
    chk("d_rvalid", d_rvalid, m_rv_d);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    cyc++;
    if (if_gnt) begin last_if_gnt = cyc; gseq.push_back(ChF); end
    if (d_gnt) begin last_d_gnt = cyc; gseq.push_back(ChD); end
    if (if_rvalid) begin last_if_rv = cyc; if_rv_cnt++; end
    if (d_rvalid) begin last_d_rv = cyc; d_rv_cnt++; end
    if (mem_req) begin mreq_cnt++; last_req_addr = mem_addr; last_req_wdata = mem_wdata; end
  end

  task automatic do_fetch(input logic [31:0] a);
    int n;
    n = 0;
    if_req = 1'b1;
    if_addr = a;
    #1;
    while (!if_gnt && n < 100) begin @(posedge clk); #2; n++; end
    chk("if_gnt_wait", if_gnt, 1'b1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    if_addr = 32'h0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    #1;
    while (!d_gnt && n < 100) begin @(posedge clk); #2; n++; end
    chk("d_gnt_wait", d_gnt, 1'b1);
    @(posedge clk);
    #1;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 300);
    chk("idle_wait", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    int n;
    int mq0;
    int drv0;
    int rv0;
    string exp_s;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;

    // Fetch read, immediate memory: rvalid three cycles after the grant.
    cfg_ready_delay = 0; cfg_rv_delay = 0; cfg_rdata = 32'h00500093;
    do_fetch(32'h10);
    wait_idle();
    chk("s1_latency", last_if_rv - last_if_gnt, 3);
    chk("s1_rdata", if_rdata, 32'h00500093);
    chk("s1_mem_addr", last_req_addr, 32'h10);

    // Both requesters held: starvation guard lets fetch in every fourth grant.
    cfg_rdata = 32'h1111;
    start = gseq.size();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
    n = 0;
    while (gseq.size() < start + 8 && n < 200) begin @(negedge clk); n++; end
    chk("s2_grant_count", gseq.size() >= start + 8, 1'b1);
    @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0; if_addr = 32'h0; d_addr = 32'h0;
    wait_idle();
    exp_s = "DDDFDDDF";
    for (int i = 0; i < 8; i++) begin
      if (start + i < gseq.size()) chk("s2_grant_seq", gseq[start + i], exp_s[i]);
    end

    // Write with memory stalling four cycles: five request cycles, no read response.
    cfg_ready_delay = 4;
    mq0 = mreq_cnt;
    drv0 = d_rv_cnt;
    do_data(1'b1, 32'h8, 32'hDEADBEEF);
    wait_idle();
    chk("s3_req_cycles", mreq_cnt - mq0, 5);
    chk("s3_no_rvalid", d_rv_cnt - drv0, 0);
    chk("s3_addr", last_req_addr, 32'h8);
    chk("s3_wdata", last_req_wdata, 32'hDEADBEEF);
    cfg_ready_delay = 0;

    // Response on the very cycle the timeout would expire: data wins, no error.
    cfg_rv_delay = 14; cfg_rdata = 32'hCAFEF00D;
    do_data(1'b0, 32'h20, 32'h0);
    wait_idle();
    chk("s4_rdata", d_rdata, 32'hCAFEF00D);
    chk("s4_err", err, 1'b0);
    chk("s4_latency", last_d_rv - last_d_gnt, 17);

    // No response at all: zero data after fifteen WAIT cycles and sticky error.
    cfg_rv_delay = -1;
    do_fetch(32'h30);
    wait_idle();
    chk("s5_rdata", if_rdata, 32'h0);
    chk("s5_err", err, 1'b1);
    chk("s5_latency", last_if_rv - last_if_gnt, 17);
    cfg_rv_delay = 0; cfg_rdata = 32'h12345678;
    do_data(1'b0, 32'h34, 32'h0);
    wait_idle();
    chk("s5_good_rdata", d_rdata, 32'h12345678);
    chk("s5_err_sticky", err, 1'b1);

    // Reset in WAIT aborts the read; a late response afterwards is ignored.
    cfg_rv_delay = -1;
    do_data(1'b0, 32'h38, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    rv0 = if_rv_cnt + d_rv_cnt;
    reset = 1'b0;
    #1;
    chk("s6_rst_busy", busy, 1'b0);
    chk("s6_rst_rdata", d_rdata, 32'h0);
    chk("s6_rst_err", err, 1'b0);
    cfg_manual = 1'b1; cfg_man_rvalid = 1'b1; cfg_man_rdata = 32'hBAD0BAD0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("s6_no_rvalid", if_rv_cnt + d_rv_cnt - rv0, 0);
    chk("s6_idle", busy, 1'b0);
    cfg_manual = 1'b0; cfg_man_rvalid = 1'b0;
    cfg_rv_delay = 0; cfg_rdata = 32'h0BADF00D;
    do_fetch(32'h40);
    wait_idle();
    chk("s6_rdata", if_rdata, 32'h0BADF00D);
    chk("s6_addr", last_req_addr, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
